// File: rtl/block_nest_pkg.sv
// Shared word-state encoding and ASCII helpers
// for the begin/end nesting checker.
package block_nest_pkg;

  typedef enum logic [3:0] {
    W_IDLE,
    W_B,
    W_BE,
    W_BEG,
    W_BEGI,
    W_BEGIN,
    W_E,
    W_EN,
    W_END,
    W_OTHER
  } word_state_e;

  localparam logic [7:0] CASE_FOLD = 8'h20;
  localparam logic [7:0] CH_A      = 8'h61;
  localparam logic [7:0] CH_Z      = 8'h7a;
  localparam logic [7:0] CH_B      = 8'h62;
  localparam logic [7:0] CH_D      = 8'h64;
  localparam logic [7:0] CH_E      = 8'h65;
  localparam logic [7:0] CH_G      = 8'h67;
  localparam logic [7:0] CH_I      = 8'h69;
  localparam logic [7:0] CH_N      = 8'h6e;

  // Folding only maps A-Z onto a-z; no other byte lands in a-z.
  function automatic logic is_letter(logic [7:0] c);
    logic [7:0] f;
    f = c | CASE_FOLD;
    return (f >= CH_A) && (f <= CH_Z);
  endfunction

endpackage

// File: rtl/block_nest_checker_if.sv
// Byte stream in, nesting status out.
// Master drives bytes, slave reports status.
interface block_nest_checker_if #(
  parameter int DEPTH_W = 8
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               result;
  logic [DEPTH_W-1:0] depth;
  logic               err_unmatched;
  logic               err_overflow;

  modport master (
    output in_valid, in_data,
    input  result, depth,
    input  err_unmatched, err_overflow
  );

  modport slave (
    input  in_valid, in_data,
    output result, depth,
    output err_unmatched, err_overflow
  );
endinterface

// File: rtl/block_nest_checker_keyword_matcher.sv
// Word FSM: tracks begin/end prefixes and flags
// keyword commits on the terminating delimiter.
module keyword_matcher
  import block_nest_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       begin_commit,
  output logic       end_commit,
  output logic       is_begin_tent,
  output logic       is_end_tent
);

  word_state_e state_q;
  word_state_e state_d;
  logic        letter;
  logic [7:0]  lc;
  logic        accept;

  assign letter = is_letter(in_data);
  assign lc     = in_data | CASE_FOLD;
  assign accept = in_valid & ~clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = W_IDLE;
    end else if (in_valid) begin
      if (!letter) begin
        state_d = W_IDLE;
      end else begin
        state_d = W_OTHER;
        unique case (state_q)
          W_IDLE: begin
            if (lc == CH_B) state_d = W_B;
            else if (lc == CH_E) state_d = W_E;
          end
          W_B:    if (lc == CH_E) state_d = W_BE;
          W_BE:   if (lc == CH_G) state_d = W_BEG;
          W_BEG:  if (lc == CH_I) state_d = W_BEGI;
          W_BEGI: if (lc == CH_N) state_d = W_BEGIN;
          W_E:    if (lc == CH_N) state_d = W_EN;
          W_EN:   if (lc == CH_D) state_d = W_END;
          default: state_d = W_OTHER;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= W_IDLE;
    else          state_q <= state_d;
  end

  assign is_begin_tent = (state_q == W_BEGIN);
  assign is_end_tent   = (state_q == W_END);
  assign begin_commit  = accept & ~letter & is_begin_tent;
  assign end_commit    = accept & ~letter & is_end_tent;

endmodule

// File: rtl/block_nest_checker.sv
// Depth counter, sticky error flags and the
// balanced-stream result for the byte stream.
module block_nest_checker
  import block_nest_pkg::*;
#(
  parameter int MAX_DEPTH = 255,
  parameter int STRICT    = 1,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  block_nest_checker_if.slave  bus
);

  localparam bit STRICT_B = (STRICT != 0);
  localparam logic [DEPTH_W-1:0] D_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] D_ZRO = '0;

  logic               begin_commit;
  logic               end_commit;
  logic               begin_tent;
  logic               end_tent;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               unm_q, unm_d;
  logic               ovf_q, ovf_d;

  keyword_matcher u_match (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .in_valid      (bus.in_valid),
    .in_data       (bus.in_data),
    .begin_commit  (begin_commit),
    .end_commit    (end_commit),
    .is_begin_tent (begin_tent),
    .is_end_tent   (end_tent)
  );

  always_comb begin
    depth_d = depth_q;
    unm_d   = unm_q;
    ovf_d   = ovf_q;
    if (clear) begin
      depth_d = D_ZRO;
      unm_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (begin_commit) begin
      if (depth_q == D_MAX) ovf_d = 1'b1;
      else depth_d = depth_q + D_ONE;
    end else if (end_commit) begin
      if (depth_q == D_ZRO) unm_d = 1'b1;
      else depth_d = depth_q - D_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= D_ZRO;
      unm_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      unm_q   <= unm_d;
      ovf_q   <= ovf_d;
    end
  end

  // A pending "end" balances the stream when it would close depth 1.
  logic depth_ok;
  always_comb begin
    depth_ok = (depth_q == D_ZRO);
    if (end_tent)
      depth_ok = (depth_q == D_ONE)
               | ((depth_q == D_ZRO) & ~STRICT_B);
  end

  assign bus.result = ~ovf_q
                    & ~(STRICT_B & unm_q)
                    & ~begin_tent
                    & depth_ok;
  assign bus.depth         = depth_q;
  assign bus.err_unmatched = unm_q;
  assign bus.err_overflow  = ovf_q;

endmodule
